// File: rtl/mem_burst_initiator.sv
// Burst initiator for a single-port memory bank.
// Turns one start command into a linear run of word writes or reads.
module mem_burst_initiator #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              start_ready,
    input  logic              start_write,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   start_len,
    output logic              busy,
    output logic              done,
    input  logic              wr_in_valid,
    output logic              wr_in_ready,
    input  logic [DATA_W-1:0] wr_in_data,
    output logic              rd_out_valid,
    input  logic              rd_out_ready,
    output logic [DATA_W-1:0] rd_out_data,
    output logic              rd_out_last,
    output logic              mem_chip_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data
);

    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        FINISH
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] base;
    logic [CW-1:0]     len;
    logic [CW-1:0]     count;
    logic [CW-1:0]     issued;
    logic [CW-1:0]     popped;
    logic              inflight;

    logic [DATA_W-1:0] fifo [4];
    logic [1:0]        wptr;
    logic [1:0]        rptr;
    logic [2:0]        fcnt;

    logic accept;
    logic wr_beat;
    logic issue;
    logic push;
    logic pop;
    logic at_last;

    assign start_ready  = (state == IDLE);
    assign busy         = (state != IDLE);
    assign accept       = start & start_ready;
    assign wr_beat      = (state == WR) & wr_in_valid;
    assign issue        = (state == RD) & (issued < len)
                          & ((fcnt + {2'b00, inflight}) < 3'd4);
    assign push         = inflight;
    assign rd_out_valid = (fcnt != 3'd0);
    assign pop          = rd_out_valid & rd_out_ready;
    assign at_last      = (popped == len - 1'b1);
    assign rd_out_last  = rd_out_valid & at_last;
    assign rd_out_data  = rd_out_valid ? fifo[rptr] : '0;

    // State register; reset abandons any burst in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and bank controls, all derived from state and handshakes.
    always_comb begin
        state_nx    = state;
        wr_in_ready = 1'b0;
        done        = 1'b0;
        mem_chip_en = 1'b0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (start_len == '0) begin
                        state_nx = FINISH;
                    end else if (start_write) begin
                        state_nx = WR;
                    end else begin
                        state_nx = RD;
                    end
                end
            end
            WR: begin
                wr_in_ready = 1'b1;
                if (wr_in_valid) begin
                    mem_chip_en = 1'b1;
                    mem_wr_en   = 1'b1;
                    mem_wr_addr = base + count[ADDR_W-1:0];
                    mem_wr_data = wr_in_data;
                    if (count == len - 1'b1) begin
                        state_nx = FINISH;
                    end
                end
            end
            RD: begin
                if (issue) begin
                    mem_chip_en = 1'b1;
                    mem_rd_en   = 1'b1;
                    mem_rd_addr = base + issued[ADDR_W-1:0];
                end
                if (pop && at_last) begin
                    state_nx = FINISH;
                end
            end
            FINISH: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

    // Command capture and beat counters; in-flight marks a read awaiting data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base     <= '0;
            len      <= '0;
            count    <= '0;
            issued   <= '0;
            popped   <= '0;
            inflight <= 1'b0;
        end else begin
            if (accept) begin
                base   <= start_addr;
                len    <= start_len;
                count  <= '0;
                issued <= '0;
                popped <= '0;
            end
            if (wr_beat) begin
                count <= count + 1'b1;
            end
            if (issue) begin
                issued <= issued + 1'b1;
            end
            if (pop) begin
                popped <= popped + 1'b1;
            end
            inflight <= issue;
        end
    end

    // Four-entry read FIFO absorbing returned words under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            fcnt <= '0;
            for (int i = 0; i < 4; i++) begin
                fifo[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo[wptr] <= mem_rd_data;
                wptr       <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                fcnt <= fcnt + 1'b1;
            end else if (pop && !push) begin
                fcnt <= fcnt - 1'b1;
            end
        end
    end

    a_no_rw_overlap: assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_wr_en && mem_rd_en));

    a_strobe_needs_ce: assert property (@(posedge clk) disable iff (!rst_n)
        !((mem_wr_en || mem_rd_en) && !mem_chip_en));

    a_ce_quiet: assert property (@(posedge clk) disable iff (!rst_n)
        (state == IDLE || state == FINISH) |-> !mem_chip_en);

    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && fcnt == 3'd4));

    a_fifo_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && fcnt == 3'd0));

    a_len_legal: assert property (@(posedge clk) disable iff (!rst_n)
        accept |-> (start_len <= DEPTH));

endmodule

// File: tb/tb_mem_burst_initiator.sv
// Directed bench for mem_burst_initiator with a behavioural bank model.
// Bus activity is logged once per cycle and checked per scenario.
module tb_mem_burst_initiator;

    localparam int DW = 16;
    localparam int AW = 10;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          start_ready;
    logic          start_write;
    logic [AW-1:0] start_addr;
    logic [AW:0]   start_len;
    logic          busy;
    logic          done;
    logic          wr_in_valid;
    logic          wr_in_ready;
    logic [DW-1:0] wr_in_data;
    logic          rd_out_valid;
    logic          rd_out_ready;
    logic [DW-1:0] rd_out_data;
    logic          rd_out_last;
    logic          mem_chip_en;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;

    mem_burst_initiator #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .start_ready(start_ready),
        .start_write(start_write),
        .start_addr(start_addr),
        .start_len(start_len),
        .busy(busy),
        .done(done),
        .wr_in_valid(wr_in_valid),
        .wr_in_ready(wr_in_ready),
        .wr_in_data(wr_in_data),
        .rd_out_valid(rd_out_valid),
        .rd_out_ready(rd_out_ready),
        .rd_out_data(rd_out_data),
        .rd_out_last(rd_out_last),
        .mem_chip_en(mem_chip_en),
        .mem_wr_en(mem_wr_en),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] bank [1024];
    logic [DW-1:0] wdata [16];
    logic [59:0]   obs;

    int            cyc = 0;
    bit            busy_hist [4096];
    bit            ce_hist [4096];
    int            w_cyc [$];
    logic [AW-1:0] w_addr [$];
    logic [DW-1:0] w_dat [$];
    int            r_cyc [$];
    logic [AW-1:0] r_addr [$];
    int            o_cyc [$];
    logic [DW-1:0] o_dat [$];
    logic          o_last [$];
    int            d_cyc [$];
    int            a_cyc [$];
    int            ce_cnt = 0;
    int            sr_bad = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bank model: writes land at the edge, read data returns one cycle later.
    always @(posedge clk) begin
        if (mem_chip_en === 1'b1 && mem_wr_en === 1'b1) begin
            bank[mem_wr_addr] <= mem_wr_data;
        end
        if (mem_chip_en === 1'b1 && mem_rd_en === 1'b1) begin
            mem_rd_data <= bank[mem_rd_addr];
        end
    end

    // Per-cycle log, sampled mid-cycle after inputs settle.
    always begin
        @(negedge clk);
        #2;
        busy_hist[cyc % 4096] = busy;
        ce_hist[cyc % 4096]   = mem_chip_en;
        if (mem_chip_en === 1'b1) ce_cnt++;
        if (mem_chip_en === 1'b1 && mem_wr_en === 1'b1) begin
            w_cyc.push_back(cyc);
            w_addr.push_back(mem_wr_addr);
            w_dat.push_back(mem_wr_data);
        end
        if (mem_chip_en === 1'b1 && mem_rd_en === 1'b1) begin
            r_cyc.push_back(cyc);
            r_addr.push_back(mem_rd_addr);
        end
        if (rd_out_valid === 1'b1 && rd_out_ready === 1'b1) begin
            o_cyc.push_back(cyc);
            o_dat.push_back(rd_out_data);
            o_last.push_back(rd_out_last);
        end
        if (done === 1'b1) d_cyc.push_back(cyc);
        if (start === 1'b1 && start_ready === 1'b1) a_cyc.push_back(cyc);
        if (busy === 1'b1 && start_ready === 1'b1) sr_bad++;
        cyc++;
    end

    task automatic clear_logs();
        w_cyc.delete();
        w_addr.delete();
        w_dat.delete();
        r_cyc.delete();
        r_addr.delete();
        o_cyc.delete();
        o_dat.delete();
        o_last.delete();
        d_cyc.delete();
        a_cyc.delete();
        ce_cnt = 0;
        sr_bad = 0;
    endtask

    task automatic send_start(input logic w, input logic [AW-1:0] a,
                              input logic [AW:0] l);
        @(negedge clk);
        start       = 1'b1;
        start_write = w;
        start_addr  = a;
        start_len   = l;
        #1;
        for (int k = 0; k < 20 && start_ready !== 1'b1; k++) begin
            @(negedge clk);
            #1;
        end
        if (start_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL start_timeout: start_ready=%b want 1", start_ready);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive_wr(input int n, input int gap_after, input int gap_len);
        for (int i = 0; i < n; i++) begin
            wr_in_valid = 1'b1;
            wr_in_data  = wdata[i];
            @(negedge clk);
            if (i == gap_after) begin
                wr_in_valid = 1'b0;
                repeat (gap_len) @(negedge clk);
            end
        end
        wr_in_valid = 1'b0;
        wr_in_data  = '0;
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int k = 0; k < 200 && !idle; k++) begin
            @(negedge clk);
            if (busy === 1'b0) idle = 1'b1;
        end
        if (!idle) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: busy=%b want 0", busy);
        end
        #3;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        start        = 1'b0;
        start_write  = 1'b0;
        start_addr   = '0;
        start_len    = '0;
        wr_in_valid  = 1'b0;
        wr_in_data   = '0;
        rd_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #2;
        obs = {busy, done, wr_in_ready, rd_out_valid, rd_out_data, rd_out_last,
               mem_chip_en, mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en,
               mem_rd_addr};
        n_cmp++;
        if (obs !== 60'd0) begin
            n_bad++;
            $display("FAIL reset_outs: got %h want 0", obs);
        end
        n_cmp++;
        if (start_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_start_ready: got %b want 1", start_ready);
        end
    endtask

    task automatic test_write_gap();
        for (int i = 0; i < 4; i++) wdata[i] = 16'h00A0 + 16'(i);
        clear_logs();
        send_start(1'b1, 10'd5, 11'd4);
        drive_wr(4, 1, 2);
        wait_idle();
        n_cmp++;
        if (w_addr.size() !== 4) begin
            n_bad++;
            $display("FAIL wr_count: got %0d want 4", w_addr.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (w_addr[i] !== 10'(5 + i) || w_dat[i] !== 16'h00A0 + 16'(i)) begin
                n_bad++;
                $display("FAIL wr_beat%0d: got %0d/%h want %0d/%h",
                         i, w_addr[i], w_dat[i], 5 + i, 16'h00A0 + 16'(i));
            end
        end
        n_cmp++;
        if (w_cyc[2] - w_cyc[1] !== 3) begin
            n_bad++;
            $display("FAIL wr_gap_len: got %0d want 3", w_cyc[2] - w_cyc[1]);
        end
        n_cmp++;
        if ({ce_hist[(w_cyc[1] + 1) % 4096], ce_hist[(w_cyc[1] + 2) % 4096]} !== 2'b00) begin
            n_bad++;
            $display("FAIL wr_gap_ce: got %b%b want 00",
                     ce_hist[(w_cyc[1] + 1) % 4096], ce_hist[(w_cyc[1] + 2) % 4096]);
        end
        n_cmp++;
        if (ce_cnt !== 4) begin
            n_bad++;
            $display("FAIL wr_ce_cycles: got %0d want 4", ce_cnt);
        end
        n_cmp++;
        if (d_cyc.size() !== 1 || d_cyc[0] !== w_cyc[3] + 1) begin
            n_bad++;
            $display("FAIL wr_done_time: got %0d (n=%0d) want %0d",
                     d_cyc[0], d_cyc.size(), w_cyc[3] + 1);
        end
        n_cmp++;
        if (busy_hist[(d_cyc[0] + 1) % 4096] !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_busy_after: got %b want 0",
                     busy_hist[(d_cyc[0] + 1) % 4096]);
        end
    endtask

    task automatic test_read_stream();
        clear_logs();
        rd_out_ready = 1'b1;
        send_start(1'b0, 10'd5, 11'd4);
        wait_idle();
        n_cmp++;
        if (o_dat.size() !== 4 || r_addr.size() !== 4) begin
            n_bad++;
            $display("FAIL rd_counts: got %0d/%0d want 4/4", o_dat.size(), r_addr.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (r_addr[i] !== 10'(5 + i) || o_dat[i] !== 16'h00A0 + 16'(i)
                || o_last[i] !== (i == 3) || o_cyc[i] !== o_cyc[0] + i) begin
                n_bad++;
                $display("FAIL rd_beat%0d: got a=%0d d=%h l=%b c=%0d want a=%0d d=%h l=%b c=%0d",
                         i, r_addr[i], o_dat[i], o_last[i], o_cyc[i],
                         5 + i, 16'h00A0 + 16'(i), (i == 3), o_cyc[0] + i);
            end
        end
        n_cmp++;
        if (o_cyc[0] !== r_cyc[0] + 2) begin
            n_bad++;
            $display("FAIL rd_first_latency: got %0d want 2", o_cyc[0] - r_cyc[0]);
        end
        n_cmp++;
        if (d_cyc.size() !== 1 || d_cyc[0] !== o_cyc[3] + 1) begin
            n_bad++;
            $display("FAIL rd_done_time: got %0d want %0d", d_cyc[0], o_cyc[3] + 1);
        end
    endtask

    task automatic test_backpressure();
        int mo;
        int pb;
        for (int i = 0; i < 8; i++) wdata[i] = 16'h5100 + 16'(i);
        clear_logs();
        send_start(1'b1, 10'd100, 11'd8);
        drive_wr(8, -1, 0);
        wait_idle();
        clear_logs();
        rd_out_ready = 1'b1;
        send_start(1'b0, 10'd100, 11'd8);
        repeat (3) @(negedge clk);
        rd_out_ready = 1'b0;
        repeat (6) @(negedge clk);
        rd_out_ready = 1'b1;
        wait_idle();
        n_cmp++;
        if (o_dat.size() !== 8 || r_addr.size() !== 8) begin
            n_bad++;
            $display("FAIL bp_counts: got %0d/%0d want 8/8", o_dat.size(), r_addr.size());
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (o_dat[i] !== 16'h5100 + 16'(i) || r_addr[i] !== 10'(100 + i)) begin
                n_bad++;
                $display("FAIL bp_beat%0d: got %h@%0d want %h@%0d",
                         i, o_dat[i], r_addr[i], 16'h5100 + 16'(i), 100 + i);
            end
        end
        mo = 0;
        for (int j = 0; j < r_cyc.size(); j++) begin
            pb = 0;
            for (int k = 0; k < o_cyc.size(); k++) begin
                if (o_cyc[k] < r_cyc[j]) pb++;
            end
            if (j - pb > mo) mo = j - pb;
        end
        n_cmp++;
        if (mo !== 3) begin
            n_bad++;
            $display("FAIL bp_outstanding: got %0d want 3", mo);
        end
        n_cmp++;
        if (d_cyc.size() !== 1) begin
            n_bad++;
            $display("FAIL bp_done: got %0d want 1", d_cyc.size());
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] ea [4];
        ea[0] = 10'd1022;
        ea[1] = 10'd1023;
        ea[2] = 10'd0;
        ea[3] = 10'd1;
        for (int i = 0; i < 4; i++) wdata[i] = 16'h00C0 + 16'(i);
        clear_logs();
        send_start(1'b1, 10'd1022, 11'd4);
        drive_wr(4, -1, 0);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (w_addr[i] !== ea[i]) begin
                n_bad++;
                $display("FAIL wrap_wr_addr%0d: got %0d want %0d", i, w_addr[i], ea[i]);
            end
        end
        clear_logs();
        rd_out_ready = 1'b1;
        send_start(1'b0, 10'd1022, 11'd4);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (r_addr[i] !== ea[i] || o_dat[i] !== 16'h00C0 + 16'(i)) begin
                n_bad++;
                $display("FAIL wrap_rd%0d: got %h@%0d want %h@%0d",
                         i, o_dat[i], r_addr[i], 16'h00C0 + 16'(i), ea[i]);
            end
        end
    endtask

    task automatic test_zero_and_ignore();
        clear_logs();
        send_start(1'b0, 10'd7, 11'd0);
        wait_idle();
        n_cmp++;
        if (a_cyc.size() !== 1 || d_cyc.size() !== 1 || d_cyc[0] !== a_cyc[0] + 1) begin
            n_bad++;
            $display("FAIL zero_done: got %0d want %0d", d_cyc[0], a_cyc[0] + 1);
        end
        n_cmp++;
        if (ce_cnt !== 0) begin
            n_bad++;
            $display("FAIL zero_ce: got %0d want 0", ce_cnt);
        end
        wdata[0] = 16'h0B00;
        wdata[1] = 16'h0B01;
        clear_logs();
        send_start(1'b1, 10'd300, 11'd2);
        start       = 1'b1;
        start_write = 1'b0;
        start_addr  = 10'd0;
        start_len   = 11'd5;
        drive_wr(2, -1, 0);
        start = 1'b0;
        wait_idle();
        n_cmp++;
        if (a_cyc.size() !== 1 || sr_bad !== 0 || r_addr.size() !== 0) begin
            n_bad++;
            $display("FAIL ignore_start: got acc=%0d sr_busy=%0d rd=%0d want 1/0/0",
                     a_cyc.size(), sr_bad, r_addr.size());
        end
        n_cmp++;
        if (w_addr.size() !== 2 || w_addr[0] !== 10'd300 || w_addr[1] !== 10'd301) begin
            n_bad++;
            $display("FAIL ignore_wr: got n=%0d %0d,%0d want 2 300,301",
                     w_addr.size(), w_addr[0], w_addr[1]);
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        rd_out_ready = 1'b0;
        send_start(1'b0, 10'd5, 11'd8);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        obs = {busy, done, wr_in_ready, rd_out_valid, rd_out_data, rd_out_last,
               mem_chip_en, mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en,
               mem_rd_addr};
        n_cmp++;
        if (obs !== 60'd0 || start_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_outs: got %h sr=%b want 0 sr=1", obs, start_ready);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (d_cyc.size() !== 0 || o_cyc.size() !== 0) begin
            n_bad++;
            $display("FAIL midrst_quiet: got done=%0d beats=%0d want 0/0",
                     d_cyc.size(), o_cyc.size());
        end
        rd_out_ready = 1'b1;
        wdata[0] = 16'h00E0;
        wdata[1] = 16'h00E1;
        clear_logs();
        send_start(1'b1, 10'd400, 11'd2);
        drive_wr(2, -1, 0);
        wait_idle();
        n_cmp++;
        if (w_addr.size() !== 2 || w_addr[0] !== 10'd400 || w_dat[1] !== 16'h00E1
            || d_cyc.size() !== 1) begin
            n_bad++;
            $display("FAIL midrst_wr: got n=%0d a0=%0d d1=%h done=%0d want 2 400 e1 1",
                     w_addr.size(), w_addr[0], w_dat[1], d_cyc.size());
        end
        clear_logs();
        send_start(1'b0, 10'd400, 11'd2);
        wait_idle();
        n_cmp++;
        if (o_dat.size() !== 2 || o_dat[0] !== 16'h00E0 || o_dat[1] !== 16'h00E1) begin
            n_bad++;
            $display("FAIL midrst_rd: got n=%0d %h,%h want 2 e0,e1",
                     o_dat.size(), o_dat[0], o_dat[1]);
        end
    endtask

    initial begin
        test_reset();
        test_write_gap();
        test_read_stream();
        test_backpressure();
        test_wrap();
        test_zero_and_ignore();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_burst_initiator.md
Name: mem_burst_initiator

Overview:
- Initiator side of the single-port memory bank interface: drives chip enable, write strobe/address/data and read strobe/address; captures read data.
- Converts one start command (base, length, direction) into a linear burst of word accesses.
- Write data enters on a valid/ready stream; read data leaves on a valid/ready stream with backpressure.
- Sits between compute/DMA logic and one memory bank; guarantees the bank never sees simultaneous read and write, or access with chip enable low.

Parameters:
- DATA_W, 16, memory word width in bits.
- ADDR_W, 10, memory address width in bits; bank depth = 2^ADDR_W.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  command valid.
- start_ready  out  1  command accepted when start & start_ready.
- start_write  in  1  1 = write burst, 0 = read burst.
- start_addr  in  ADDR_W  burst base address.
- start_len  in  ADDR_W+1  word count, 0..2^ADDR_W.
- busy  out  1  burst in progress.
- done  out  1  one-cycle completion pulse.
- wr_in_valid  in  1  write beat valid.
- wr_in_ready  out  1  write beat accepted.
- wr_in_data  in  DATA_W  write beat data.
- rd_out_valid  out  1  read beat valid.
- rd_out_ready  in  1  downstream ready.
- rd_out_data  out  DATA_W  read beat data.
- rd_out_last  out  1  final beat of burst, qualified by rd_out_valid.
- mem_chip_en  out  1  bank chip enable.
- mem_wr_en  out  1  bank write strobe.
- mem_wr_addr  out  ADDR_W  bank write address.
- mem_wr_data  out  DATA_W  bank write data.
- mem_rd_en  out  1  bank read strobe.
- mem_rd_addr  out  ADDR_W  bank read address.
- mem_rd_data  in  DATA_W  bank read data; valid the cycle after a read is issued.

Behaviour:
- States: IDLE, WR, RD, FINISH.
- Reset (rst_n low at a clock edge): state IDLE; counters, in-flight flag and FIFO cleared. Next cycle: all outputs 0 except start_ready = 1.
- A reset mid-burst abandons the burst: no done pulse, FIFO contents dropped.
- start_ready = (state == IDLE). Command fields are captured on handshake. start while not IDLE is ignored.
- start_len == 0 -> FINISH; no memory access.
- busy = (state != IDLE).
- FINISH lasts one cycle, drives done = 1, then returns to IDLE.
- Memory controls are combinational from state and handshakes; the bank samples them on the next edge.
- Beat i address = (base + i) mod 2^ADDR_W, so bursts wrap at the top of the bank.
- start_len > 2^ADDR_W is illegal; flag with an assertion.
- WR state:
  - wr_in_ready = 1.
  - On wr_in_valid: mem_chip_en = 1, mem_wr_en = 1, mem_wr_addr = base + count, mem_wr_data = wr_in_data; count increments.
  - After beat len-1 is accepted -> FINISH.
  - Gaps in wr_in_valid insert idle cycles with mem_chip_en = 0.
- RD state:
  - Fixed 4-entry output FIFO plus a 1-bit in-flight flag.
  - Issue a read when issued < len and (fifo_count + inflight) < 4: mem_chip_en = 1, mem_rd_en = 1, mem_rd_addr = base + issued. The in-flight flag is set at that edge.
  - Cycle after an issue: mem_rd_data is pushed into the FIFO at the end of that cycle.
  - rd_out_valid = FIFO non-empty. Beat pops on rd_out_valid & rd_out_ready.
  - Push and pop in the same cycle keep the count unchanged.
  - rd_out_last is asserted on beat len-1.
  - After the last beat pops -> FINISH.
  - First rd_out_valid appears 2 cycles after the first mem_rd_en.
  - With rd_out_ready held high: one beat per cycle, no bubbles.
- Invariants (assert every cycle):
  - Never mem_wr_en & mem_rd_en.
  - Never (mem_wr_en | mem_rd_en) & ~mem_chip_en.
  - mem_chip_en = 0 in IDLE and FINISH.
  - FIFO never overflows or underflows.
- Counter widths are ADDR_W+1; address arithmetic truncates to ADDR_W.

Test Plan:
- Write base 5, len 4, data 0xA0..0xA3 with a 2-cycle gap after beat 1 -> bank writes addr 5..8; mem_chip_en low during the gap; done pulses 1 cycle after beat 3; busy low on the following cycle.
- Read base 5, len 4, rd_out_ready = 1 -> rd_out_data 0xA0, 0xA1, 0xA2, 0xA3 on consecutive cycles, first beat 2 cycles after the first mem_rd_en; rd_out_last only on 0xA3; then done.
- Read len 8 with rd_out_ready low for 6 cycles mid-burst -> mem_rd_en stops once FIFO + in-flight = 4; all 8 words delivered in order, none lost or duplicated.
- Wrap, ADDR_W = 10: write then read base 1022, len 4 -> addresses 1022, 1023, 0, 1 in order; data round-trips.
- start_len = 0 -> done one cycle after accept, mem_chip_en never high. Second start during a burst -> ignored; start_ready low throughout.
- rst_n low for one cycle mid read burst -> all outputs 0 next cycle, no done pulse; a new write burst of len 2 then completes normally.
